// File: rtl/purifier_scan_if.sv
// purifier_scan_if: scan-enable, raw lines and filtered-level/event bundle of the glitch filter
interface purifier_scan_if #(parameter int CHANNELS = 8);
  localparam int IW = $clog2(CHANNELS);
  logic                en_i;
  logic [CHANNELS-1:0] in_i;
  logic [CHANNELS-1:0] out_o;
  logic                chg_stb_o;
  logic [IW-1:0]       chg_idx_o;
  logic                chg_val_o;
  logic [IW-1:0]       scan_idx_o;
  modport slave (input en_i, in_i, output out_o, chg_stb_o, chg_idx_o, chg_val_o, scan_idx_o);
  modport master (output en_i, in_i, input out_o, chg_stb_o, chg_idx_o, chg_val_o, scan_idx_o);
endinterface

// File: rtl/purifier_scan.sv
// purifier_scan: round-robin debouncer, one shared compare/count datapath over all channels
module purifier_scan #(
  parameter int CHANNELS  = 8,
  parameter int CNT_W     = 4,
  parameter int THRESH    = 4,
  parameter int PRESCALE  = 1,
  parameter bit RESET_VAL = 1'b1
) (
  input logic clk,
  input logic reset,
  purifier_scan_if.slave bus
);
  localparam int IW = $clog2(CHANNELS);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic [CHANNELS-1:0] s1_q, s2_q, out_q, out_d;
  logic [CHANNELS-1:0][CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [IW-1:0] ptr_q, ptr_d, idx_q, idx_d;
  logic stb_q, stb_d, val_q, val_d;
  logic tick, s, dis, hit;
  always_comb begin
    tick  = bus.en_i && pre_q == PW'(PRESCALE - 1);
    s     = s2_q[ptr_q];
    dis   = s != out_q[ptr_q];
    hit   = tick && dis && cnt_q[ptr_q] == CNT_W'(THRESH - 1);
    pre_d = !bus.en_i ? pre_q : tick ? '0 : pre_q + 1'b1;
    ptr_d = !tick ? ptr_q : ptr_q == IW'(CHANNELS - 1) ? '0 : ptr_q + 1'b1;
    // counts measure disagreement with out, so any agreeing visit or acceptance restarts them
    cnt_d = dis && !hit ? cnt_q[ptr_q] + 1'b1 : '0;
    out_d = out_q;
    if (hit) out_d[ptr_q] = s;
    stb_d = hit;
    idx_d = hit ? ptr_q : idx_q;
    val_d = hit ? s : val_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q  <= {CHANNELS{RESET_VAL}};
      s2_q  <= {CHANNELS{RESET_VAL}};
      out_q <= {CHANNELS{RESET_VAL}};
      cnt_q <= '0;
      pre_q <= '0;
      ptr_q <= '0;
      stb_q <= 1'b0;
      idx_q <= '0;
      val_q <= 1'b0;
    end else begin
      s1_q  <= bus.in_i;
      s2_q  <= s1_q;
      out_q <= out_d;
      if (tick) cnt_q[ptr_q] <= cnt_d;
      pre_q <= pre_d;
      ptr_q <= ptr_d;
      stb_q <= stb_d;
      idx_q <= idx_d;
      val_q <= val_d;
    end
  end
  assign bus.out_o      = out_q;
  assign bus.chg_stb_o  = stb_q;
  assign bus.chg_idx_o  = idx_q;
  assign bus.chg_val_o  = val_q;
  assign bus.scan_idx_o = ptr_q;
endmodule
